// File: rtl/ofifo_rr_drain_ctrl.sv
// Round-robin drain controller: grants bursts of reads across nfifo output FIFOs
// and forwards each word through a single registered valid/ready stage.
module ofifo_rr_drain_ctrl #(
  parameter int bw    = 4,
  parameter int simd  = 1,
  parameter int nfifo = 4
) (
  input  logic                         rd_clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [3:0]                   cfg_burst,
  input  logic [nfifo-1:0]             fifo_empty,
  input  logic [nfifo*simd*bw-1:0]     fifo_out,
  output logic [nfifo-1:0]             fifo_rd,
  output logic [simd*bw-1:0]           out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(nfifo)-1:0]     out_src,
  output logic                         busy,
  output logic [15:0]                  word_cnt
);

  localparam int sw = $clog2(nfifo);
  localparam int ww = simd * bw;

  typedef enum logic [1:0] {IDLE, SEL, XFER} state_t;

  state_t         state, state_nxt;
  logic [sw-1:0]  grant, last_grant, pick, rr_idx;
  logic           pick_ok;
  logic [3:0]     burst_cnt, burst_load;
  logic           rd_en;

  always_comb begin
    burst_load = cfg_burst;
    if (cfg_burst == 4'd0 || cfg_burst > 4'd8) burst_load = 4'd8;
  end

  // Search starts one past the last grant; index wraps naturally since nfifo is a power of 2.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    rr_idx  = '0;
    for (int unsigned k = 0; k < nfifo; k++) begin
      rr_idx = last_grant + sw'(k + 1);
      if (!pick_ok && !fifo_empty[rr_idx]) begin
        pick    = rr_idx;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    rd_en = (state == XFER) && !reset && enable && !fifo_empty[grant] &&
            (burst_cnt != 4'd0) && (!out_valid || out_ready);
    fifo_rd = '0;
    if (rd_en) fifo_rd[grant] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable && !(&fifo_empty)) state_nxt = SEL;
      SEL:  state_nxt = (enable && pick_ok) ? XFER : IDLE;
      XFER: begin
        if (!enable)
          state_nxt = IDLE;
        else if ((rd_en && burst_cnt == 4'd1) || burst_cnt == 4'd0 ||
                 (fifo_empty[grant] && !rd_en))
          state_nxt = SEL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= sw'(nfifo - 1);
      grant      <= '0;
      burst_cnt  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      word_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == SEL && state_nxt == XFER) begin
        grant     <= pick;
        burst_cnt <= burst_load;
      end
      if (state == XFER && state_nxt != XFER) last_grant <= grant;
      // A read replaces the held word even when it is consumed on the same edge.
      if (rd_en) begin
        out_data  <= fifo_out[grant*ww +: ww];
        out_src   <= grant;
        out_valid <= 1'b1;
        burst_cnt <= burst_cnt - 4'd1;
        word_cnt  <= word_cnt + 16'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ofifo_rr_drain_ctrl.sv
// Bench for ofifo_rr_drain_ctrl: queue-modelled FIFOs, scoreboard of expected
// words, a table of single-FIFO burst vectors and hand-written corner sequences.
module tb_ofifo_rr_drain_ctrl;

  localparam int NF = 4;
  localparam int WW = 4;

  logic              rd_clk = 1'b0;
  logic              reset, enable, out_ready;
  logic [3:0]        cfg_burst;
  logic [NF-1:0]     fifo_empty;
  logic [NF*WW-1:0]  fifo_out;
  logic [NF-1:0]     fifo_rd;
  logic [WW-1:0]     out_data;
  logic              out_valid;
  logic [1:0]        out_src;
  logic              busy;
  logic [15:0]       word_cnt;

  always #5 rd_clk = ~rd_clk;

  ofifo_rr_drain_ctrl #(.bw(4), .simd(1), .nfifo(NF)) dut (
    .rd_clk(rd_clk), .reset(reset), .enable(enable), .cfg_burst(cfg_burst),
    .fifo_empty(fifo_empty), .fifo_out(fifo_out), .fifo_rd(fifo_rd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .busy(busy), .word_cnt(word_cnt)
  );

  typedef logic [WW-1:0] wq_t[$];
  typedef struct { logic [1:0] src; logic [WW-1:0] data; } exp_t;
  typedef struct { int src; int n; logic [3:0] cfg; int exp_runs; int exp_max; } vec_t;

  wq_t           fq[NF];
  exp_t          sb[$];
  vec_t          tbl[7];
  int            n_chk = 0, n_fail = 0;
  int            runs, maxrun, cur_run;
  logic [NF-1:0] prev_rd;
  logic [15:0]   base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NF; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_out[i*WW +: WW] = fifo_empty[i] ? '0 : fq[i][0];
    end
  endtask

  task automatic load(input int f, input int n, input bit push_sb);
    logic [WW-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = WW'($urandom_range(15, 0));
      fq[f].push_back(d);
      if (push_sb) sb.push_back('{src: 2'(f), data: d});
    end
    refresh();
  endtask

  function automatic bit all_empty();
    return (fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()) == 0;
  endfunction

  // Sample on the falling edge, let the FIFO model pop on the rising edge.
  task automatic tick();
    logic [NF-1:0] rd_s;
    logic          cons;
    exp_t          e;
    @(negedge rd_clk);
    rd_s = fifo_rd;
    cons = !reset && out_valid && out_ready;
    if (rd_s != '0) begin
      check("rd_onehot", $countones(rd_s), 1);
      check("rd_to_empty", rd_s & fifo_empty, 0);
      if (rd_s != prev_rd) begin runs++; cur_run = 0; end
      cur_run++;
      if (cur_run > maxrun) maxrun = cur_run;
    end
    prev_rd = rd_s;
    if (cons) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_unexpected: got word %0h src %0d, expected none", out_data, out_src);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_src", out_src, e.src);
      end
    end
    @(posedge rd_clk);
    for (int i = 0; i < NF; i++)
      if (rd_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    #1 refresh();
  endtask

  task automatic drain(input int limit);
    int c = 0;
    while (!(all_empty() && !out_valid && !busy) && c < limit) begin
      tick();
      c++;
    end
    check("drain_done", c < limit, 1);
    check("sb_empty", sb.size(), 0);
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int limit);
    int c = 0;
    while (word_cnt != target && c < limit) begin
      tick();
      c++;
    end
    check("wait_word_cnt", word_cnt, target);
  endtask

  initial begin
    tbl[0] = '{src: 1, n: 8, cfg: 4'd3,  exp_runs: 3, exp_max: 3};
    tbl[1] = '{src: 0, n: 8, cfg: 4'd0,  exp_runs: 1, exp_max: 8};
    tbl[2] = '{src: 2, n: 8, cfg: 4'd9,  exp_runs: 1, exp_max: 8};
    tbl[3] = '{src: 3, n: 8, cfg: 4'd15, exp_runs: 1, exp_max: 8};
    tbl[4] = '{src: 1, n: 5, cfg: 4'd1,  exp_runs: 5, exp_max: 1};
    tbl[5] = '{src: 2, n: 4, cfg: 4'd4,  exp_runs: 1, exp_max: 4};
    tbl[6] = '{src: 0, n: 3, cfg: 4'd2,  exp_runs: 2, exp_max: 2};

    prev_rd = '0; runs = 0; maxrun = 0; cur_run = 0;
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1; cfg_burst = 4'd2;
    refresh();

    // Reset state, with data present and enable high
    for (int f = 0; f < NF; f++) load(f, 2, 1);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    tick();
    check("rst_hold_busy", busy, 0);
    reset = 1'b0;

    // Four FIFOs x 2 words, burst 2: order 0,0,1,1,2,2,3,3
    drain(100);
    check("rr_word_cnt", word_cnt, 8);
    check("rr_idle", busy, 0);

    // Single-FIFO burst vectors
    foreach (tbl[v]) begin
      runs = 0; maxrun = 0; cur_run = 0; prev_rd = '0;
      base = word_cnt;
      cfg_burst = tbl[v].cfg;
      load(tbl[v].src, tbl[v].n, 1);
      drain(200);
      check("vec_runs", runs, tbl[v].exp_runs);
      check("vec_max_burst", maxrun, tbl[v].exp_max);
      check("vec_words", 16'(word_cnt - base), 16'(tbl[v].n));
    end

    // Backpressure: one word lands, then reads stall
    cfg_burst = 4'd4; out_ready = 1'b0;
    base = word_cnt;
    load(0, 4, 1);
    for (int c = 0; c < 20 && !out_valid; c++) tick();
    check("bp_first_valid", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, sb[0].data);
      check("bp_fifo_rd", fifo_rd, 0);
      check("bp_fifo_level", fq[0].size(), 3);
      check("bp_word_cnt", word_cnt, 16'(base + 16'd1));
    end
    out_ready = 1'b1;
    drain(100);
    check("bp_total", word_cnt, 16'(base + 16'd4));

    // Granted FIFO runs dry before the burst ends
    cfg_burst = 4'd8;
    load(2, 1, 1);
    load(3, 2, 1);
    drain(100);

    // Reset mid-burst; last_grant returns to nfifo-1
    cfg_burst = 4'd2;
    base = word_cnt;
    load(1, 6, 1);
    wait_cnt(16'(base + 16'd3), 40);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_word_cnt", word_cnt, 0);
    check("mid_rst_fifo_rd", fifo_rd, 0);
    check("mid_rst_f1_left", fq[1].size(), 3);
    sb.delete();
    load(0, 1, 0);
    load(2, 1, 0);
    sb.push_back('{src: 2'd0, data: fq[0][0]});
    sb.push_back('{src: 2'd1, data: fq[1][0]});
    sb.push_back('{src: 2'd1, data: fq[1][1]});
    sb.push_back('{src: 2'd2, data: fq[2][0]});
    sb.push_back('{src: 2'd1, data: fq[1][2]});
    tick();
    reset = 1'b0;
    drain(100);
    check("post_rst_words", word_cnt, 5);

    // Enable dropped mid-burst; held word still delivered
    cfg_burst = 4'd8;
    base = word_cnt;
    load(3, 6, 1);
    wait_cnt(16'(base + 16'd2), 40);
    enable = 1'b0; out_ready = 1'b0;
    #1;
    check("en_off_fifo_rd", fifo_rd, 0);
    tick();
    check("en_off_idle", busy, 0);
    check("en_off_valid", out_valid, 1);
    check("en_off_data", out_data, sb[0].data);
    check("en_off_src", out_src, 3);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("en_off_no_rd", fifo_rd, 0);
      check("en_off_word_cnt", word_cnt, 16'(base + 16'd2));
    end
    out_ready = 1'b1;
    tick();
    check("en_off_consumed", out_valid, 0);
    check("en_off_f3_left", fq[3].size(), 4);
    enable = 1'b1;
    drain(100);
    check("en_on_total", word_cnt, 16'(base + 16'd6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ofifo_rr_drain_ctrl.md
OFIFO_RR_DRAIN_CTRL -- requirements
Module: ofifo_rr_drain_ctrl

Interface
REQ-001 SHALL have parameter: bw, 4, bits per lane.
REQ-002 SHALL have parameter: simd, 1, lanes per FIFO word.
REQ-003 SHALL have parameter: nfifo, 4, number of depth-8 FIFOs drained (power of 2, 2..8).
REQ-004 SHALL have port: rd_clk  input  1  read-side clock, shared with all drained FIFOs.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: enable  input  1  permits new FIFO reads when high.
REQ-007 SHALL have port: cfg_burst  input  4  max words per grant; 0 means 8, values >8 clamp to 8.
REQ-008 SHALL have port: fifo_empty  input  nfifo  per-FIFO o_empty flag.
REQ-009 SHALL have port: fifo_out  input  nfifo*simd*bw  per-FIFO head word; FIFO i occupies slice i.
REQ-010 SHALL have port: fifo_rd  output  nfifo  one-hot read strobe to FIFO i.
REQ-011 SHALL have port: out_data  output  simd*bw  registered drained word.
REQ-012 SHALL have port: out_valid  output  1  out_data holds an unconsumed word.
REQ-013 SHALL have port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-014 SHALL have port: out_src  output  log2(nfifo)  index of the FIFO out_data came from.
REQ-015 SHALL have port: busy  output  1  high when FSM not in IDLE.
REQ-016 SHALL have port: word_cnt  output  16  total words drained since reset, wraps at 2^16.

Function
REQ-017 SHALL implement FSM states IDLE, SEL, XFER (registered state).
REQ-018 SHALL in IDLE go to SEL when enable=1 and any fifo_empty bit is 0.
REQ-019 SHALL in SEL pick the first non-empty FIFO searching from (last_grant+1) mod nfifo upward, register it as grant, load burst counter from clamped cfg_burst, go XFER; if none non-empty or enable=0, go IDLE.
REQ-020 SHALL in XFER assert fifo_rd[grant] combinationally iff enable=1, fifo_empty[grant]=0, burst count not exhausted, and (out_valid=0 or out_ready=1); all other fifo_rd bits 0.
REQ-021 SHALL on the rd_clk edge ending a cycle with fifo_rd asserted: load out_data from fifo_out slice grant, set out_src=grant, set out_valid=1, decrement burst count, increment word_cnt.
REQ-022 SHALL clear out_valid on an edge where out_valid=1, out_ready=1 and no read was issued; read-and-consume in the same cycle keeps out_valid=1 (1 word/cycle sustained).
REQ-023 SHALL leave XFER to SEL when burst count reaches 0, or when fifo_empty[grant]=1 with no read issued; last_grant updates to grant on exit.
REQ-024 SHALL leave XFER to IDLE when enable=0; out_valid/out_data retained until consumed.
REQ-025 SHALL never assert fifo_rd outside XFER or to an empty FIFO; backpressure (out_ready=0, out_valid=1) stalls reads without advancing burst count.
REQ-026 SHALL sample cfg_burst only in SEL; changes during XFER take effect next grant.
REQ-027 SHALL assert busy combinationally from state != IDLE.

Reset
REQ-028 SHALL on reset=1 asynchronously force state=IDLE, last_grant=nfifo-1, grant=0, burst count=0, out_valid=0, out_data=0, out_src=0, word_cnt=0; fifo_rd=0 while reset high.
REQ-029 SHALL treat reset mid-XFER identically; any word held in out_data is discarded, FIFO contents not yet strobed remain in the FIFO.

Verification
REQ-030 SHALL cover: nfifo=4, FIFOs 0..3 each hold 2 words, cfg_burst=2, out_ready=1 -> words emerge FIFO0,0,1,1,2,2,3,3, out_src follows, word_cnt=8, then IDLE.
REQ-031 SHALL cover: FIFO1 holds 8 words, others empty, cfg_burst=3 -> bursts of 3,3,2 each separated by one SEL cycle, all from out_src=1.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles after first word -> out_valid stays 1, out_data stable, fifo_rd=0, burst count unchanged; resumes on out_ready=1.
REQ-033 SHALL cover: FIFO2 empties after 1 word with cfg_burst=8 -> exits XFER when fifo_empty[2]=1, next grant goes to FIFO3 (or wraps to 0).
REQ-034 SHALL cover: reset pulsed mid-burst -> out_valid=0, busy=0, word_cnt=0 immediately; after release, first grant goes to FIFO0.
REQ-035 SHALL cover: enable dropped mid-burst -> no further fifo_rd, state IDLE next cycle, pending out_data still delivered on out_ready.
